// File: rtl/tracking_history_arbiter.sv
// Tracking-loop request initiator: gathers tagged accumulations per channel, keeps per-channel
// loop history, issues one tracking request at a time and forwards loop results back to channels.
module tracking_history_arbiter #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned I2Q2_W       = 38,
    parameter int unsigned IQ_W         = 19,
    parameter int unsigned ACC_W        = 16,
    parameter int unsigned W_DF_W       = 24,
    parameter int unsigned W_DF_DOT_W   = 24,
    parameter int unsigned DOPPLER_W    = 17,
    parameter int unsigned CA_INC_W     = 15,
    parameter int unsigned TAU_W        = 21,
    parameter int unsigned TIMEOUT      = 1023,
    localparam int unsigned CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  acc_valid,
    input  logic [CH_W-1:0]       acc_tag,
    input  logic [I2Q2_W-1:0]     acc_i2q2_early,
    input  logic [I2Q2_W-1:0]     acc_i2q2_prompt,
    input  logic [I2Q2_W-1:0]     acc_i2q2_late,
    input  logic [ACC_W-1:0]      acc_i_prompt,
    input  logic [ACC_W-1:0]      acc_q_prompt,
    input  logic                  chan_init,
    input  logic [CH_W-1:0]       chan_init_tag,
    input  logic [W_DF_W-1:0]     chan_init_w_df,
    output logic                  i2q2_valid,
    output logic [I2Q2_W-1:0]     i2q2_early_k,
    output logic [I2Q2_W-1:0]     i2q2_prompt_k,
    output logic [I2Q2_W-1:0]     i2q2_late_k,
    output logic [ACC_W-1:0]      i_prompt_k,
    output logic [ACC_W-1:0]      q_prompt_k,
    output logic [ACC_W-1:0]      i_prompt_km1,
    output logic [ACC_W-1:0]      q_prompt_km1,
    output logic [IQ_W-1:0]       iq_prompt_km1,
    output logic [W_DF_W-1:0]     w_df_k,
    output logic [W_DF_DOT_W-1:0] w_df_dot_k,
    input  logic                  tracking_ready,
    input  logic [IQ_W-1:0]       iq_prompt_k,
    input  logic [DOPPLER_W-1:0]  doppler_inc_kp1,
    input  logic [W_DF_W-1:0]     w_df_kp1,
    input  logic [W_DF_DOT_W-1:0] w_df_dot_kp1,
    input  logic [CA_INC_W-1:0]   ca_dphi_kp1,
    input  logic [TAU_W-1:0]      tau_prime_kp1,
    output logic                  update_valid,
    output logic [CH_W-1:0]       update_tag,
    output logic [DOPPLER_W-1:0]  update_doppler_inc,
    output logic [CA_INC_W-1:0]   update_ca_dphi,
    output logic [TAU_W-1:0]      update_tau_prime,
    output logic                  overrun,
    output logic                  timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_WRITEBACK} state_e;

    state_e                  state_q;
    logic [CH_W-1:0]         tag_q;
    logic [CH_W-1:0]         ptr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    kill_q;
    logic [NUM_CHANNELS-1:0] pending_q;

    logic [I2Q2_W-1:0]     snap_e_q [NUM_CHANNELS];
    logic [I2Q2_W-1:0]     snap_p_q [NUM_CHANNELS];
    logic [I2Q2_W-1:0]     snap_l_q [NUM_CHANNELS];
    logic [ACC_W-1:0]      snap_i_q [NUM_CHANNELS];
    logic [ACC_W-1:0]      snap_q_q [NUM_CHANNELS];

    logic [ACC_W-1:0]      hist_i_q   [NUM_CHANNELS];
    logic [ACC_W-1:0]      hist_q_q   [NUM_CHANNELS];
    logic [IQ_W-1:0]       hist_iq_q  [NUM_CHANNELS];
    logic [W_DF_W-1:0]     hist_wdf_q [NUM_CHANNELS];
    logic [W_DF_DOT_W-1:0] hist_dot_q [NUM_CHANNELS];

    logic            sel_found_c;
    logic [CH_W-1:0] sel_tag_c;
    logic            take_c;
    logic            hit_c;
    logic            wb_fire_c;

    // Round-robin pick: first pending channel at or after the pointer, wrapping.
    always_comb begin
        int unsigned idx;
        sel_found_c = 1'b0;
        sel_tag_c   = '0;
        for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
            if (!sel_found_c && pending_q[CH_W'(idx)]) begin
                sel_found_c = 1'b1;
                sel_tag_c   = CH_W'(idx);
            end
        end
    end

    assign take_c    = (state_q == ST_IDLE) && sel_found_c;
    assign hit_c     = chan_init && (chan_init_tag == tag_q);
    assign wb_fire_c = (state_q == ST_WAIT) && tracking_ready && !kill_q && !hit_c;

    // Snapshot intake; no reset dependency on the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                snap_e_q[c] <= '0;
                snap_p_q[c] <= '0;
                snap_l_q[c] <= '0;
                snap_i_q[c] <= '0;
                snap_q_q[c] <= '0;
            end
        end else if (acc_valid) begin
            snap_e_q[acc_tag] <= acc_i2q2_early;
            snap_p_q[acc_tag] <= acc_i2q2_prompt;
            snap_l_q[acc_tag] <= acc_i2q2_late;
            snap_i_q[acc_tag] <= acc_i_prompt;
            snap_q_q[acc_tag] <= acc_q_prompt;
        end
    end

    // A snapshot consumed by this cycle's selection is not counted as overwritten.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            overrun   <= 1'b0;
        end else begin
            overrun <= acc_valid && pending_q[acc_tag] && !(take_c && (sel_tag_c == acc_tag));
            if (take_c) pending_q[sel_tag_c] <= 1'b0;
            if (acc_valid) pending_q[acc_tag] <= 1'b1;
        end
    end

    // History: loop writeback, then channel init (init wins on the same tag).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                hist_i_q[c]   <= '0;
                hist_q_q[c]   <= '0;
                hist_iq_q[c]  <= '0;
                hist_wdf_q[c] <= '0;
                hist_dot_q[c] <= '0;
            end
        end else begin
            if (wb_fire_c) begin
                hist_i_q[tag_q]   <= i_prompt_k;
                hist_q_q[tag_q]   <= q_prompt_k;
                hist_iq_q[tag_q]  <= iq_prompt_k;
                hist_wdf_q[tag_q] <= w_df_kp1;
                hist_dot_q[tag_q] <= w_df_dot_kp1;
            end
            if (chan_init) begin
                hist_i_q[chan_init_tag]   <= '0;
                hist_q_q[chan_init_tag]   <= '0;
                hist_iq_q[chan_init_tag]  <= '0;
                hist_wdf_q[chan_init_tag] <= chan_init_w_df;
                hist_dot_q[chan_init_tag] <= '0;
            end
        end
    end

    // Request/result sequencer with registered strobes and held operands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= ST_IDLE;
            tag_q              <= '0;
            ptr_q              <= '0;
            cnt_q              <= '0;
            kill_q             <= 1'b0;
            i2q2_valid         <= 1'b0;
            i2q2_early_k       <= '0;
            i2q2_prompt_k      <= '0;
            i2q2_late_k        <= '0;
            i_prompt_k         <= '0;
            q_prompt_k         <= '0;
            i_prompt_km1       <= '0;
            q_prompt_km1       <= '0;
            iq_prompt_km1      <= '0;
            w_df_k             <= '0;
            w_df_dot_k         <= '0;
            update_valid       <= 1'b0;
            update_tag         <= '0;
            update_doppler_inc <= '0;
            update_ca_dphi     <= '0;
            update_tau_prime   <= '0;
            timeout_err        <= 1'b0;
        end else begin
            i2q2_valid   <= 1'b0;
            update_valid <= 1'b0;
            timeout_err  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sel_found_c) begin
                        tag_q         <= sel_tag_c;
                        kill_q        <= chan_init && (chan_init_tag == sel_tag_c);
                        i2q2_early_k  <= snap_e_q[sel_tag_c];
                        i2q2_prompt_k <= snap_p_q[sel_tag_c];
                        i2q2_late_k   <= snap_l_q[sel_tag_c];
                        i_prompt_k    <= snap_i_q[sel_tag_c];
                        q_prompt_k    <= snap_q_q[sel_tag_c];
                        i_prompt_km1  <= hist_i_q[sel_tag_c];
                        q_prompt_km1  <= hist_q_q[sel_tag_c];
                        iq_prompt_km1 <= hist_iq_q[sel_tag_c];
                        w_df_k        <= hist_wdf_q[sel_tag_c];
                        w_df_dot_k    <= hist_dot_q[sel_tag_c];
                        i2q2_valid    <= 1'b1;
                        state_q       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    kill_q  <= kill_q | hit_c;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    kill_q <= kill_q | hit_c;
                    if (tracking_ready) begin
                        update_valid       <= wb_fire_c;
                        update_tag         <= tag_q;
                        update_doppler_inc <= doppler_inc_kp1;
                        update_ca_dphi     <= ca_dphi_kp1;
                        update_tau_prime   <= tau_prime_kp1;
                        state_q            <= ST_WRITEBACK;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WRITEBACK: begin
                    ptr_q   <= (tag_q == CH_W'(NUM_CHANNELS - 1)) ? '0 : tag_q + CH_W'(1);
                    kill_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
